// File: rtl/edge_emitter_pkg.sv
// Shared state encoding and sizing helpers for the edge_emitter pulse generator.
// The FSM encoding is fixed so other logic can decode the state bits directly.
package edge_emitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a down-counter holding 0 .. n-1.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/edge_emitter.sv
// Turns one-cycle request ticks into spaced level pulses on a single line,
// queueing requests that arrive while a pulse is in flight (saturating).
module edge_emitter
    import edge_emitter_pkg::*;
#(
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 2,
    parameter int PENDING_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 en,
    output logic                 out,
    output logic                 busy,
    output logic [PENDING_W-1:0] pending,
    output logic                 overflow
);

    localparam int                   CNT_W       = cnt_width(max_int(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [CNT_W-1:0]     HIGH_LOAD   = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]     LOW_LOAD    = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PENDING_W-1:0] PENDING_MAX = '1;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 pol_q, pol_d;
    logic                 overflow_q, overflow_d;
    logic [PENDING_W-1:0] pending_q, pending_d;

    logic start;      // a pulse begins at this edge
    logic take_tick;  // this cycle's tick starts the pulse directly
    logic pop;        // the pulse that begins comes from the queue
    logic push;       // this cycle's tick has to wait in the queue

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_q      <= 1'b0;
            pol_q      <= 1'b0;
            overflow_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            pol_q      <= pol_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        pol_d     = pol_q;
        start     = 1'b0;
        take_tick = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = ~en;
                if (tick) begin
                    start     = 1'b1;
                    take_tick = 1'b1;
                end
            end
            ACTIVE: begin
                out_d = pol_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = GAP;
                    out_d   = ~pol_q;
                    cnt_d   = LOW_LOAD;
                end
            end
            GAP: begin
                // Holding ~pol into the first IDLE cycle keeps the full gap even if en moved.
                out_d = ~pol_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pending_q != '0) begin
                    start = 1'b1;
                    pop   = 1'b1;
                end else if (tick) begin
                    start     = 1'b1;
                    take_tick = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = ~en;
            end
        endcase

        if (start) begin
            state_d = ACTIVE;
            pol_d   = en;
            out_d   = en;
            cnt_d   = HIGH_LOAD;
        end
    end

    // Saturating queue of requests not yet started.
    always_comb begin
        push       = tick & ~take_tick;
        pending_d  = pending_q;
        overflow_d = 1'b0;
        if (push && !pop) begin
            if (pending_q == PENDING_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PENDING_W'(1);
            end
        end else if (pop && !push) begin
            pending_d = pending_q - PENDING_W'(1);
        end
    end

    assign out      = out_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | (pending_q != '0);

endmodule

// File: doc/edge_emitter.md
Name: edge_emitter

Overview:
- Transmit-side counterpart of the single-input rising-edge trigger; converts one-cycle request ticks into clean, spaced level pulses on a single output line.
- Each accepted request produces exactly one active-level pulse followed by a guaranteed inactive gap, so every request is detectable as one edge downstream.
- Requests arriving while a pulse is in flight are counted, not lost, up to a saturation limit.
- Sits between internal event logic (timers, FSMs) and output pins or other clock-domain-local edge-detected lines.

Parameters:
- HIGH_CYCLES, 3, cycles `out` holds the active level per pulse (>=1)
- LOW_CYCLES, 2, minimum cycles `out` holds the inactive level after each pulse (>=1)
- PENDING_W, 2, width of the pending-request counter; max queued = 2^PENDING_W-1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- tick  in  1  one-cycle request strobe, sampled each clk
- en  in  1  active level of emitted pulse (1 = high pulse, 0 = low pulse); quasi-static
- out  out  1  registered emitted line
- busy  out  1  1 while state != IDLE or pending != 0
- pending  out  PENDING_W  queued requests not yet started
- overflow  out  1  one-cycle strobe: a tick was dropped

Behaviour:
- Interface (decided): one clock `clk`; reset `reset` is asynchronous and active-low.
- Reset values: state=IDLE, out=0, pending=0, overflow=0, cnt=0, pol=0.
- After reset release, IDLE drives out <= ~en each cycle (registered); one cycle of out=0 before settling is acceptable.
- States: IDLE, ACTIVE, GAP. `cnt` is sized to max(HIGH_CYCLES, LOW_CYCLES).
- IDLE:
  - tick=1 -> ACTIVE, pol<=en, out<=en, cnt<=HIGH_CYCLES-1.
  - Pending is always 0 in IDLE.
- ACTIVE:
  - out=pol.
  - cnt!=0 -> cnt-1.
  - cnt==0 -> GAP, out<=~pol, cnt<=LOW_CYCLES-1.
- GAP:
  - out=~pol.
  - cnt!=0 -> cnt-1.
  - cnt==0 and (pending!=0 or tick) -> ACTIVE; reload as in IDLE.
  - cnt==0 otherwise -> IDLE.
- Latency: tick sampled at edge N in IDLE -> out active on cycles N+1..N+HIGH_CYCLES; inactive N+HIGH_CYCLES+1..N+HIGH_CYCLES+LOW_CYCLES. Pulse period = HIGH_CYCLES+LOW_CYCLES.
- Pending arithmetic, per cycle:
  - inc = tick and not (tick consumed directly this cycle).
  - dec = GAP end starts a pulse from queue (pending!=0).
  - A direct start at GAP end from tick with pending==0 is neither inc nor dec.
  - inc and dec together -> pending unchanged (tick queued, oldest started).
  - inc at pending==max -> pending holds, overflow=1 for that cycle.
  - overflow is registered: asserted the cycle after the dropped tick.
- Polarity: pol is latched at each pulse start. An en change mid-pulse takes effect only at the next pulse start or in IDLE.
- Wrap-around: none; pending saturates, never wraps.
- Reset mid-pulse: immediate return to reset values; queued requests are discarded.
- busy = (state!=IDLE) | (pending!=0), combinational from registers.

Decomposition:
- Shared include file: state encodings (IDLE=2'd0, ACTIVE=2'd1, GAP=2'd2).
- Single module. The saturating pending counter is small and stays inline; no sub-module.

Test Plan:
- en=1, single tick at cycle 10 -> out=1 cycles 11-13, 0 cycles 14-15, busy=0 from 16, pending=0 throughout.
- en=1, ticks at 10 and 11 -> pending=1 at cycle 12; second pulse out=1 cycles 16-18; pending=0 at 17; exactly 2 rising edges on out.
- en=1, ticks on cycles 10-14 (5 ticks) -> pending reaches 3, overflow pulses once at cycle 15, exactly 4 pulses emitted, with 2-cycle gaps.
- en=0, tick at 10 -> idle out=1; out=0 cycles 11-13; back to 1 at 14. Toggling en to 1 at cycle 12 does not alter the in-flight pulse.
- Tick exactly on the final GAP cycle (cycle 15 after tick at 10), pending=0 -> next pulse starts cycle 16, pending stays 0, no IDLE cycle.
- reset=0 at cycle 12 mid-pulse with pending=2 -> out=0, pending=0, busy=0 immediately (async); after release, out=~en and no further pulses emitted.
